// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_N = 64;

  // Quotient reported on divide-by-zero; truncated to the instance width.
  localparam logic [MAX_N-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/divisor_secuencial_if.sv
// Start/ready/valid handshake and operand/result bus of the divider.
interface divisor_secuencial_if #(
  parameter int unsigned N = 32
);

  logic         start_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         ready_o;
  logic         valid_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );

endinterface

// File: rtl/restador_n.sv
// W-bit subtractor a - b as a ripple of full adders on ~b with carry-in 1.
module restador_n #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W-1:0] nb;

  assign nb = ~b;

  // One full adder per bit; carry ripples LSB to MSB, final carry-out means a >= b.
  always_comb begin
    logic carry;
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < int'(W); i++) begin
      diff[i] = a[i] ^ nb[i] ^ carry;
      carry   = (a[i] & nb[i]) | (carry & (a[i] ^ nb[i]));
    end
    no_borrow = carry;
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Iterative unsigned restoring divider: one quotient bit per clock, N+2 cycles per result.
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input logic               clk,
  input logic               rst_n,
  divisor_secuencial_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned TW = N + 1;

  state_t        state, state_n;
  logic [N-1:0]  rem, rem_n;
  logic [N-1:0]  q, q_n;
  logic [N-1:0]  d, d_n;
  logic [CW-1:0] count, count_n;
  logic [N-1:0]  quotient, quotient_n;
  logic [N-1:0]  remainder, remainder_n;
  logic          div_zero, div_zero_n;
  logic          ready, ready_n;
  logic          valid, valid_n;

  logic [TW-1:0] trial;
  logic [TW-1:0] diff;
  logic [TW-1:0] rem_sel;
  logic          no_borrow;
  logic [N-1:0]  rem_step;
  logic [N-1:0]  q_step;
  logic          unused_rem_msb;

  // Trial value is one bit wider than the operands so divisors above 2^(N-1) cannot overflow.
  assign trial = {rem, q[N-1]};

  restador_n #(
    .W (TW)
  ) u_restador (
    .a         (trial),
    .b         ({1'b0, d}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // The partial remainder is always below d, so the top bit of the selected value is zero.
  assign rem_sel        = no_borrow ? diff : trial;
  assign rem_step       = rem_sel[N-1:0];
  assign unused_rem_msb = rem_sel[N];
  assign q_step         = {q[N-2:0], no_borrow};

  // Next-state, datapath and result update.
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    q_n         = q;
    d_n         = d;
    count_n     = count;
    quotient_n  = quotient;
    remainder_n = remainder;
    div_zero_n  = div_zero;

    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.divisor_i == '0) begin
            quotient_n  = N'(DIV_ZERO_Q);
            remainder_n = bus.dividend_i;
            div_zero_n  = 1'b1;
            state_n     = DONE;
          end else begin
            d_n     = bus.divisor_i;
            rem_n   = '0;
            q_n     = bus.dividend_i;
            count_n = CW'(N);
            state_n = CALC;
          end
        end
      end
      CALC: begin
        rem_n   = rem_step;
        q_n     = q_step;
        count_n = count - CW'(1);
        if (count == CW'(1)) begin
          quotient_n  = q_step;
          remainder_n = rem_step;
          div_zero_n  = 1'b0;
          state_n     = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign ready_n = (state_n == IDLE);
  assign valid_n = (state_n == DONE);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ready     <= 1'b1;
      valid     <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      q         <= q_n;
      d         <= d_n;
      count     <= count_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      div_zero  <= div_zero_n;
      ready     <= ready_n;
      valid     <= valid_n;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = valid;
  assign bus.quotient_o  = quotient;
  assign bus.remainder_o = remainder;
  assign bus.div_zero_o  = div_zero;

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Iterative unsigned restoring divider for the vector-processor datapath.
- Computes dividend / divisor, one quotient bit per clock, by repeated trial subtraction.
- Each trial subtraction is the add-with-inverted-operand built from the team's ripple full-adder.
- Used by vector-lane integer divide ops through a start/ready/valid handshake.

Parameters:
- N, 32, operand, quotient and remainder width in bits (N >= 2)
- CW, $clog2(N+1), iteration-counter width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_i  input  1  request; sampled only when ready_o=1
- dividend_i  input  N  unsigned dividend, latched on accepted start
- divisor_i  input  N  unsigned divisor, latched on accepted start
- ready_o  input-accept indicator, output  1  high in IDLE only
- valid_o  output  1  one-cycle pulse; results valid
- quotient_o  output  N  quotient, held until next accepted start
- remainder_o  output  N  remainder, held until next accepted start
- div_zero_o  output  1  divisor was zero, held with results

Behaviour:
- Reset: asynchronous, active-low.
  - Any state goes to IDLE.
  - Output values during reset: ready_o=1, valid_o=0, quotient_o=0, remainder_o=0, div_zero_o=0.
  - All internal registers and the counter are cleared.
  - Reset mid-operation aborts the division; no valid_o follows.
- Three states, IDLE, CALC and DONE, with these transitions:
  - IDLE, start_i=1, divisor_i=0: go to DONE; quotient={N{1}}, remainder=dividend_i, div_zero=1.
  - IDLE, start_i=1, divisor_i!=0: latch operands; rem=0, q=dividend; count=N; div_zero=0; go to CALC.
  - IDLE, start_i=0: stay in IDLE.
  - CALC, each cycle: run one restoring step; decrement count; go to DONE when count reaches 1.
  - DONE: valid_o=1 for exactly one cycle, then return to IDLE.
- Restoring step (all in CALC):
  - t = {rem[N-1:0], q[N-1]} (N+1 bits).
  - diff = t - {1'b0, d}, computed as t + ~{1'b0, d} + 1 with carry-in 1.
  - Carry-out 1 means t >= d: rem = diff[N-1:0], q = {q[N-2:0], 1'b1}.
  - Otherwise: rem = t[N-1:0], q = {q[N-2:0], 1'b0}.
  - The N+1-bit width avoids overflow when d > 2^(N-1).
- Latency, with start accepted at edge 0:
  - Normal: N CALC cycles; valid_o high in cycle N+1 (cycle 33 for N=32).
  - Divide-by-zero: valid_o high in cycle 1.
- start_i while ready_o=0 (CALC or DONE) is ignored and is not queued.
- Operands changing after acceptance have no effect.
- quotient_o, remainder_o and div_zero_o update only on entry to DONE. They are stable from the valid_o cycle until the next completion.
- Back-to-back: a start in the IDLE cycle directly after DONE is accepted. Throughput is one result per N+2 cycles.
- Edge cases:
  - dividend < divisor: q=0, rem=dividend.
  - dividend = 0: q=0, rem=0.
  - divisor = 1: q=dividend, rem=0.

Decomposition:
- Shared package div_pkg:
  - state enum: IDLE, CALC, DONE
  - constant DIV_ZERO_Q = all ones
- One natural sub-module: restador_n, an (N+1)-bit subtractor.
  - Implemented as a ripple of 1-bit full adders with inverted B and Cin=1.
  - Outputs the difference plus a borrow-free flag (carry-out).
- No other sub-modules. FSM, counter and shift registers stay in the top module.

Test Plan:
- N=32, 100/7: valid_o pulses once at cycle 33 with quotient_o=14, remainder_o=2, div_zero_o=0; ready_o low in cycles 1-33.
- N=32, 0xFFFFFFFF/1 then 0xFFFFFFFF/0x80000001: first gives q=0xFFFFFFFF, r=0. Second gives q=1, r=0x7FFFFFFE, exercising the N+1-bit trial path.
- N=32, 5/0: valid_o at cycle 1 with q=0xFFFFFFFF, r=5, div_zero_o=1. A following 9/3 gives q=3, r=0, div_zero_o=0.
- N=32, 3/10 accepted; at cycle 5 assert start_i with 50/5. The second request is ignored: a single valid_o gives q=0, r=3. Outputs then hold until a new start.
- N=32, 1000/3 accepted; rst_n pulsed low at cycle 10 (asynchronous, mid-edge). Outputs go to reset values at once and no valid_o appears. Then 1000/3 gives q=333, r=1 at 33 cycles after acceptance.
- N=8, exhaustive over all 65536 operand pairs, compared against a reference model (divisor 0 gives q=0xFF, r=dividend). Every valid_o occurs exactly 9 cycles after start (1 for divide-by-zero).
